// File: rtl/axi4_interconnect_pkg.sv
// -----------------------------------------------------------------------------
// axi4_interconnect_pkg
// Shared types and defaults for the AXI4 interconnect write-channel arbiter.
//   arb_state_t          : write arbiter FSM states (IDLE, ADDR, DATA)
//   DEFAULT_NUM_MASTERS  : default number of requesting masters
//   DEFAULT_QOS_WIDTH    : default AWQOS width per master
// -----------------------------------------------------------------------------
package axi4_interconnect_pkg;

    localparam int DEFAULT_NUM_MASTERS = 10;
    localparam int DEFAULT_QOS_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axi4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_rr_arbiter
// Combinational round-robin pick: scans req starting at ptr, wrapping from
// N-1 back to 0, and returns the first set bit.
// Ports:
//   req    in  N      request mask (already QoS-filtered by the caller)
//   ptr    in  IDX_W  index where the search starts (must be < N)
//   onehot out N      one-hot winner, zero when no request
//   idx    out IDX_W  binary index of the winner, zero when no request
//   any    out 1      at least one request present
// -----------------------------------------------------------------------------
module axi4_rr_arbiter #(
    parameter int N     = 10,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves a variable unassigned would otherwise infer a latch.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/axi4_write_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_write_arbiter
// Arbitrates the AW/W channels of one slave among NUM_MASTERS masters. A
// grant is issued from IDLE, held through the address handshake (ADDR) and
// the last write beat (DATA), then released for one idle cycle.
// Optional feature: define AXI4_WRITE_ARB_QOS_EN to restrict each pick to the
// requesters carrying the highest req_qos; ties still go round-robin.
// Ports:
//   aclk        in  1                     clock, rising edge
//   aresetn     in  1                     asynchronous active-low reset
//   req         in  NUM_MASTERS           per-master AWVALID for this slave
//   req_qos     in  NUM_MASTERS*QOS_WIDTH per-master AWQOS, master i at [i*QOS_WIDTH +: QOS_WIDTH]
//   aw_hs       in  1                     AWVALID&AWREADY on the muxed channel
//   w_last_hs   in  1                     WVALID&WREADY&WLAST on the muxed channel
//   grant       out NUM_MASTERS           one-hot grant (mux selects)
//   grant_id    out clog2(NUM_MASTERS)    binary index of the grant
//   grant_valid out 1                     a grant is active
//   busy        out 1                     FSM is not IDLE
// -----------------------------------------------------------------------------
module axi4_write_arbiter
    import axi4_interconnect_pkg::*;
#(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int QOS_WIDTH   = DEFAULT_QOS_WIDTH
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_MASTERS-1:0]           req,
    input  logic [NUM_MASTERS*QOS_WIDTH-1:0] req_qos,
    input  logic                             aw_hs,
    input  logic                             w_last_hs,
    output logic [NUM_MASTERS-1:0]           grant,
    output logic [$clog2(NUM_MASTERS)-1:0]   grant_id,
    output logic                             grant_valid,
    output logic                             busy
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    arb_state_t             state, state_n;
    logic [IDX_W-1:0]       rr_ptr, rr_ptr_n;
    logic                   wdone, wdone_n;
    logic [NUM_MASTERS-1:0] grant_n;
    logic [IDX_W-1:0]       grant_id_n;
    logic                   grant_valid_n;
    logic                   burst_done;

    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;

`ifdef AXI4_WRITE_ARB_QOS_EN
    logic [QOS_WIDTH-1:0] max_qos;

    // Two passes: find the highest QoS among live requests, then keep only
    // the requests carrying it.
    always_comb begin
        max_qos  = '0;
        eligible = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (req[i] && (req_qos[i*QOS_WIDTH +: QOS_WIDTH] > max_qos)) begin
                max_qos = req_qos[i*QOS_WIDTH +: QOS_WIDTH];
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            eligible[i] = req[i] && (req_qos[i*QOS_WIDTH +: QOS_WIDTH] == max_qos);
        end
    end
`else
    // QoS ignored in this build; the port stays for a uniform interface.
    logic qos_unused;
    assign qos_unused = ^req_qos;
    assign eligible   = req;
`endif

    axi4_rr_arbiter #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req    (eligible),
        .ptr    (rr_ptr),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    // Burst ends on the address handshake if the last beat already went by
    // (or goes by now), otherwise on the last beat while in DATA.
    assign burst_done = ((state == ADDR) && aw_hs && (wdone || w_last_hs)) ||
                        ((state == DATA) && w_last_hs);

    // NOTE: combinational next-state logic uses blocking assignments so later
    // statements see earlier ones within the same evaluation.
    always_comb begin
        state_n       = state;
        rr_ptr_n      = rr_ptr;
        wdone_n       = wdone;
        grant_n       = grant;
        grant_id_n    = grant_id;
        grant_valid_n = grant_valid;

        unique case (state)
            IDLE: begin
                // Handshakes seen here belong to no burst and are ignored.
                wdone_n       = 1'b0;
                grant_n       = '0;
                grant_id_n    = '0;
                grant_valid_n = 1'b0;
                if (win_any) begin
                    state_n       = ADDR;
                    grant_n       = win_onehot;
                    grant_id_n    = win_idx;
                    grant_valid_n = 1'b1;
                end
            end
            ADDR: begin
                // Grant is held regardless of req: AWVALID may not be dropped.
                if (aw_hs) begin
                    state_n = DATA;
                end else if (w_last_hs) begin
                    wdone_n = 1'b1;
                end
            end
            DATA: begin
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (burst_done) begin
            state_n       = IDLE;
            wdone_n       = 1'b0;
            grant_n       = '0;
            grant_id_n    = '0;
            grant_valid_n = 1'b0;
            rr_ptr_n      = (grant_id == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            wdone       <= 1'b0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            wdone       <= wdone_n;
            grant       <= grant_n;
            grant_id    <= grant_id_n;
            grant_valid <= grant_valid_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_axi4_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi4_write_arbiter
// Directed bench for axi4_write_arbiter. Stimulus pushes the expected winner
// into a scoreboard queue; a monitor pops it whenever a new grant appears.
// Honours AXI4_WRITE_ARB_QOS_EN for the QoS vector.
// -----------------------------------------------------------------------------
module tb_axi4_write_arbiter;

    localparam int N  = 10;
    localparam int QW = 4;

`ifdef AXI4_WRITE_ARB_QOS_EN
    localparam int QOS_EXP = 1;
`else
    localparam int QOS_EXP = 0;
`endif

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*QW-1:0] req_qos = '0;
    logic            aw_hs = 1'b0;
    logic            w_last_hs = 1'b0;
    logic [N-1:0]    grant;
    logic [3:0]      grant_id;
    logic            grant_valid;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    int sb[$];
    logic gv_prev = 1'b0;
    int   mon_exp;

    axi4_write_arbiter #(
        .NUM_MASTERS (N),
        .QOS_WIDTH   (QW)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req         (req),
        .req_qos     (req_qos),
        .aw_hs       (aw_hs),
        .w_last_hs   (w_last_hs),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .busy        (busy)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a rising grant_valid is a new grant; compare with the queue.
    always @(negedge aclk) begin
        if (grant_valid === 1'b1 && gv_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant: got id %0d expected no grant", grant_id);
            end else begin
                mon_exp = sb.pop_front();
                check("grant_id", 32'(grant_id), 32'(mon_exp));
                check("grant_onehot", 32'(grant), 32'(1) << mon_exp);
            end
        end
        if (grant_valid !== 1'b1) begin
            check("idle_grant_zero", 32'(grant), 32'd0);
            check("idle_grant_id_zero", 32'(grant_id), 32'd0);
        end
        gv_prev <= grant_valid;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_grant(output bit got);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            got = grant_valid;
        end
        if (!got) check("grant_timeout", 32'(grant_valid), 32'd1);
    endtask

    task automatic do_reset();
        aw_hs     = 1'b0;
        w_last_hs = 1'b0;
        aresetn   = 1'b0;
        #2;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // One burst: expect exp_id granted, then drive the handshakes.
    //   aw_wait : cycles in ADDR before aw_hs
    //   w_after : cycles from aw_hs to w_last_hs (0 = same cycle)
    //   w_first : w_last_hs pulsed in ADDR before aw_hs
    task automatic do_burst(input int exp_id, input logic [N-1:0] req_after,
                            input int aw_wait, input int w_after, input bit w_first);
        bit got;
        sb.push_back(exp_id);
        wait_grant(got);
        if (!got) return;
        req = req_after;
        if (w_first) begin
            w_last_hs = 1'b1;
            tick();
            w_last_hs = 1'b0;
        end
        repeat (aw_wait) tick();
        if (aw_wait > 0 || w_first) begin
            check("hold_valid", 32'(grant_valid), 32'd1);
            check("hold_id", 32'(grant_id), 32'(exp_id));
            check("hold_busy", 32'(busy), 32'd1);
        end
        aw_hs = 1'b1;
        if (!w_first && w_after == 0) w_last_hs = 1'b1;
        tick();
        aw_hs     = 1'b0;
        w_last_hs = 1'b0;
        if (!w_first && w_after > 0) begin
            check("data_busy", 32'(busy), 32'd1);
            check("data_valid", 32'(grant_valid), 32'd1);
            repeat (w_after - 1) tick();
            w_last_hs = 1'b1;
            tick();
            w_last_hs = 1'b0;
        end
        check("done_valid", 32'(grant_valid), 32'd0);
        check("done_grant", 32'(grant), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        do_reset();

        // Stray handshakes in IDLE must change nothing (no wdone left behind).
        tick();
        aw_hs     = 1'b1;
        w_last_hs = 1'b1;
        tick();
        aw_hs     = 1'b0;
        w_last_hs = 1'b0;
        tick();
        check("idle_hs_busy", 32'(busy), 32'd0);
        check("idle_hs_valid", 32'(grant_valid), 32'd0);

        // Single requester 2; req dropped after grant must not release it.
        req = 10'b00_0000_0100;
        do_burst(2, '0, 2, 3, 1'b0);

        // rr_ptr is now 3: full request set picks master 3.
        req = 10'h3FF;
        do_burst(3, 10'h3FF, 0, 1, 1'b0);

        // From reset, all requesting: 0..9 then wrap to 0, mixing burst shapes.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            case (i % 3)
                0:       do_burst(i % 10, (i == 10) ? 10'h000 : 10'h3FF, 1, 2, 1'b0);
                1:       do_burst(i % 10, (i == 10) ? 10'h000 : 10'h3FF, 0, 0, 1'b0);
                default: do_burst(i % 10, (i == 10) ? 10'h000 : 10'h3FF, 1, 0, 1'b1);
            endcase
        end

        // Reset in DATA with master 5 granted; rr_ptr must come back at 0.
        req = 10'h020;
        sb.push_back(5);
        wait_grant(got);
        req   = 10'h000;
        aw_hs = 1'b1;
        tick();
        aw_hs = 1'b0;
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_grant_id", 32'(grant_id), 32'd0);
        check("async_rst_valid", 32'(grant_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        req = 10'h021;
        @(negedge aclk);
        aresetn = 1'b1;
        do_burst(0, '0, 0, 2, 1'b0);

        // QoS: master 1 carries the higher QoS.
        do_reset();
        req_qos = 40'h00_0000_0092;
        req     = 10'h003;
        do_burst(QOS_EXP, '0, 0, 0, 1'b0);

        tick();
        tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
